xosera_bus_host: RTL and testbench

XOSERA_BUS_HOST -- requirements
Module: xosera_bus_host

---
 rtl/xosera_bus_host.sv | 178 +++++++++++++++++
 tb/tb_xosera_bus_host.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xosera_bus_host.sv
// Word-request to Xosera 8-bit bus host: each request becomes an even then odd byte strobe,
// paced by a synchronized DTACK handshake with a per-phase timeout.
module xosera_bus_host #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [4:0]  bus_addr_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_dtack_n_i
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic        dtack_meta_q, dtack_s;
    logic        write_q, write_d;
    logic [3:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        idx_q, idx_d;
    logic        tout_q, tout_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] cnt_inc, wait_inc;
    logic        busy_d;

    assign cnt_inc  = 32'(cnt_q) + 32'd1;
    assign wait_inc = 32'(wait_q) + 32'd1;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dtack_meta_q <= 1'b1;
            dtack_s      <= 1'b1;
        end else begin
            dtack_meta_q <= bus_dtack_n_i;
            dtack_s      <= dtack_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        tout_d  = tout_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    write_d = req_write_i;
                    reg_d   = req_reg_num_i;
                    wdata_d = req_data_i;
                    rdata_d = 16'h0000;
                    idx_d   = 1'b0;
                    tout_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_inc >= SETUP_CYC) begin
                    wait_d  = 8'd0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StStrobe: begin
                wait_d = wait_q + 8'd1;
                if (!dtack_s) begin
                    if (!write_q) begin
                        if (idx_q) rdata_d[7:0]  = bus_data_i;
                        else       rdata_d[15:8] = bus_data_i;
                    end
                    cnt_d   = 4'd0;
                    wait_d  = 8'd0;
                    state_d = StHold;
                end else if (wait_inc >= TIMEOUT_CYC) begin
                    tout_d  = 1'b1;
                    cnt_d   = 4'd0;
                    wait_d  = 8'd0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q != 4'hF)          cnt_d  = cnt_q + 4'd1;
                if (wait_inc < TIMEOUT_CYC) wait_d = wait_q + 8'd1;
                // Responder must release DTACK before the next strobe may be set up.
                if (cnt_inc >= HOLD_CYC && (dtack_s || wait_inc >= TIMEOUT_CYC)) begin
                    if (!dtack_s) tout_d = 1'b1;
                    if (!idx_q && !tout_d) begin
                        idx_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = StSetup;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            reg_q   <= 4'd0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            idx_q   <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= 4'd0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // All outputs are registered from next-state values so they change glitch-free with state.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= 16'h0000;
            rsp_timeout_o <= 1'b0;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_addr_o    <= 5'd0;
            bus_data_o    <= 8'h00;
            bus_data_oe_o <= 1'b0;
        end else begin
            req_ready_o   <= (state_d == StIdle);
            rsp_valid_o   <= (state_d == StDone);
            bus_cs_n_o    <= (state_d != StStrobe);
            bus_rd_nwr_o  <= busy_d ? ~write_d : 1'b1;
            bus_data_oe_o <= busy_d & write_d;
            if (busy_d) begin
                bus_addr_o <= {reg_d, idx_d};
                bus_data_o <= idx_d ? wdata_d[7:0] : wdata_d[15:8];
            end
            if (state_d == StDone) begin
                rsp_data_o    <= rdata_d;
                rsp_timeout_o <= tout_d;
            end
        end
    end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Bench for xosera_bus_host: table-driven requests against a DTACK responder model,
// strobe/response scoreboards, plus timeout, slow-release, back-to-back and reset sequences.
module tb_xosera_bus_host;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [3:0]  req_reg_num = 4'd0;
    logic [15:0] req_data = 16'h0000;
    logic        rsp_valid, rsp_timeout;
    logic [15:0] rsp_data;
    logic        bus_cs_n, bus_rd_nwr, bus_data_oe;
    logic [4:0]  bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_dtack_n = 1'b1;

    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_timeout;
    logic [15:0] b_rsp_data;
    logic        b_cs_n, b_rd_nwr, b_oe;
    logic [4:0]  b_addr;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata = 8'hFF;
    logic        b_dtack_n = 1'b1;

    xosera_bus_host #(.SETUP_CYC(2), .HOLD_CYC(1), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_reg_num_i(req_reg_num), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_timeout_o(rsp_timeout),
        .bus_cs_n_o(bus_cs_n), .bus_rd_nwr_o(bus_rd_nwr), .bus_addr_o(bus_addr),
        .bus_data_o(bus_wdata), .bus_data_oe_o(bus_data_oe), .bus_data_i(bus_rdata),
        .bus_dtack_n_i(bus_dtack_n)
    );

    xosera_bus_host #(.SETUP_CYC(2), .HOLD_CYC(1), .TIMEOUT_CYC(8)) dut_b (
        .clk(clk), .reset_n_i(reset_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(1'b0),
        .req_reg_num_i(4'h2), .req_data_i(16'h1111),
        .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .rsp_timeout_o(b_rsp_timeout),
        .bus_cs_n_o(b_cs_n), .bus_rd_nwr_o(b_rd_nwr), .bus_addr_o(b_addr),
        .bus_data_o(b_wdata), .bus_data_oe_o(b_oe), .bus_data_i(b_rdata),
        .bus_dtack_n_i(b_dtack_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0] addr;
        logic       rd_nwr;
        logic [7:0] data;
        logic       oe;
    } strobe_t;

    typedef struct packed {
        logic [15:0] data;
        logic        tout;
    } rsp_t;

    strobe_t exp_strobes[$];
    rsp_t    exp_rsps[$];

    // Responder: acks after ack_dly cycles of cs_n low, releases rel_dly cycles after cs_n rises.
    logic [7:0] rd_even = 8'h00, rd_odd = 8'h00;
    int ack_dly = 1, rel_dly = 0;
    bit ack_odd = 1'b1;
    int lo_cnt = 0, hi_cnt = 0;

    assign bus_rdata = bus_addr[0] ? rd_odd : rd_even;

    always @(posedge clk) begin
        if (bus_cs_n) begin
            lo_cnt <= 0;
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt >= rel_dly) bus_dtack_n <= 1'b1;
        end else begin
            hi_cnt <= 0;
            lo_cnt <= lo_cnt + 1;
            if (lo_cnt >= ack_dly && (ack_odd || !bus_addr[0])) bus_dtack_n <= 1'b0;
        end
    end

    int strobes = 0, rsps = 0;
    int hi_len = 0, last_gap = 0, setup_cnt = 0;

    initial begin
        strobe_t act, exp, cur;
        rsp_t    r;
        logic    prev_cs = 1'b1, prev_rv = 1'b0;
        logic [4:0] prev_addr = 5'd0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (bus_rd_nwr && bus_data_oe) begin
                errors++;
                $display("FAIL oe_on_read: oe=%0b with rd_nwr=1, expected oe=0", bus_data_oe);
            end
            if (prev_cs && !bus_cs_n) begin
                act = '{addr: bus_addr, rd_nwr: bus_rd_nwr,
                        data: bus_data_oe ? bus_wdata : 8'h00, oe: bus_data_oe};
                if (exp_strobes.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got strobe %0h, expected none", act);
                end else begin
                    exp = exp_strobes.pop_front();
                    check("strobe", 32'(act), 32'(exp));
                end
                if (bus_addr[0]) check("odd_setup_cycles", 32'(setup_cnt), 32'd2);
                cur = act;
                last_gap = hi_len;
                strobes++;
            end else if (!bus_cs_n) begin
                if (bus_addr != cur.addr || bus_rd_nwr != cur.rd_nwr || bus_data_oe != cur.oe ||
                    (cur.oe && bus_wdata != cur.data)) begin
                    errors++;
                    $display("FAIL strobe_stable: got addr %0h, expected %0h", bus_addr, cur.addr);
                end
            end
            if (bus_addr != prev_addr) setup_cnt = 1;
            else if (bus_cs_n) setup_cnt++;
            hi_len = bus_cs_n ? (prev_cs ? hi_len + 1 : 1) : 0;
            if (rsp_valid) begin
                rsps++;
                if (prev_rv) begin
                    errors++;
                    $display("FAIL rsp_pulse: got rsp_valid high 2 cycles, expected 1");
                end
                if (exp_rsps.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp %0h, expected none", rsp_data);
                end else begin
                    r = exp_rsps.pop_front();
                    check("rsp", 32'({rsp_data, rsp_timeout}), 32'(r));
                end
            end
            prev_rv = rsp_valid;
            prev_cs = bus_cs_n;
            prev_addr = bus_addr;
        end
    end

    function automatic void push_strobes(input logic w, input logic [3:0] r, input logic [15:0] d);
        exp_strobes.push_back('{addr: {r, 1'b0}, rd_nwr: ~w, data: w ? d[15:8] : 8'h00, oe: w});
        exp_strobes.push_back('{addr: {r, 1'b1}, rd_nwr: ~w, data: w ? d[7:0] : 8'h00, oe: w});
    endfunction

    task automatic send(input logic w, input logic [3:0] r, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        req_write = w; req_reg_num = r; req_data = d; req_valid = 1'b1;
        while (!req_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int target, input string name);
        int n = 0;
        while (rsps < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rsps), 32'(target));
    endtask

    typedef struct {
        logic        write;
        logic [3:0]  reg_num;
        logic [15:0] data;
        logic [7:0]  rd_even;
        logic [7:0]  rd_odd;
        int          ack;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    vec_t b2b[3];

    initial begin
        int n, base, accepts, ready_cycles;
        int lo, falls;
        logic got, prev, tout_b;
        logic [15:0] data_b;

        vecs[0] = '{1'b1, 4'h3, 16'hA55A, 8'h00, 8'h00, 1, 16'h0000};
        vecs[1] = '{1'b0, 4'h9, 16'h0000, 8'h12, 8'h34, 1, 16'h1234};
        vecs[2] = '{1'b1, 4'hF, 16'hFFFF, 8'h00, 8'h00, 0, 16'h0000};
        vecs[3] = '{1'b0, 4'h0, 16'hFFFF, 8'h00, 8'hFF, 3, 16'h00FF};
        vecs[4] = '{1'b1, 4'h8, 16'h0001, 8'h99, 8'h99, 5, 16'h0000};
        vecs[5] = '{1'b0, 4'h5, 16'h0000, 8'hA5, 8'h5A, 0, 16'hA55A};
        b2b[0]  = '{1'b1, 4'h1, 16'h1357, 8'hC3, 8'h3C, 1, 16'h0000};
        b2b[1]  = '{1'b1, 4'h2, 16'h2468, 8'hC3, 8'h3C, 1, 16'h0000};
        b2b[2]  = '{1'b0, 4'h4, 16'h0000, 8'hC3, 8'h3C, 1, 16'hC33C};

        #12;
        check("reset_bus", 32'({bus_cs_n, bus_rd_nwr, bus_addr, bus_wdata, bus_data_oe}),
              32'({1'b1, 1'b1, 5'd0, 8'h00, 1'b0}));
        check("reset_req_rsp", 32'({req_ready, rsp_valid, rsp_timeout, rsp_data}), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            rd_even = vecs[i].rd_even;
            rd_odd  = vecs[i].rd_odd;
            ack_dly = vecs[i].ack;
            push_strobes(vecs[i].write, vecs[i].reg_num, vecs[i].data);
            exp_rsps.push_back('{data: vecs[i].exp_data, tout: 1'b0});
            base = rsps;
            send(vecs[i].write, vecs[i].reg_num, vecs[i].data);
            wait_rsps(base + 1, "vec_rsp_count");
        end
        repeat (4) @(negedge clk);
        check("rsp_data_held", 32'({rsp_data, rsp_timeout}), 32'({16'hA55A, 1'b0}));

        // Slow DTACK release: odd setup must wait for the synchronized release.
        rel_dly = 20;
        ack_dly = 1;
        rd_even = 8'h77;
        rd_odd  = 8'h88;
        push_strobes(1'b0, 4'hA, 16'h0000);
        exp_rsps.push_back('{data: 16'h7788, tout: 1'b0});
        base = rsps;
        send(1'b0, 4'hA, 16'h0000);
        wait_rsps(base + 1, "slow_release_rsp");
        check("slow_release_gap", 32'(last_gap >= 22 && last_gap <= 28), 32'd1);
        rel_dly = 0;
        repeat (25) @(negedge clk);

        // Back-to-back with req_valid held high.
        rd_even = 8'hC3;
        rd_odd  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            push_strobes(b2b[i].write, b2b[i].reg_num, b2b[i].data);
            exp_rsps.push_back('{data: b2b[i].exp_data, tout: 1'b0});
        end
        base = rsps;
        accepts = 0;
        ready_cycles = 0;
        n = 0;
        @(negedge clk);
        req_write = b2b[0].write; req_reg_num = b2b[0].reg_num; req_data = b2b[0].data;
        req_valid = 1'b1;
        while (accepts < 3 && n < 1000) begin
            if (req_ready) begin
                ready_cycles++;
                @(posedge clk);
                #1 accepts++;
                if (accepts < 3) begin
                    req_write = b2b[accepts].write;
                    req_reg_num = b2b[accepts].reg_num;
                    req_data = b2b[accepts].data;
                end
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        wait_rsps(base + 3, "b2b_rsp_count");
        check("b2b_idle_cycles", 32'(ready_cycles), 32'd3);

        // No DTACK on the short-timeout instance.
        @(negedge clk) b_req_valid = 1'b1;
        n = 0;
        while (!b_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        lo = 0; falls = 0; got = 1'b0; prev = 1'b1; tout_b = 1'b0; data_b = 16'hDEAD;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (!b_cs_n) lo++;
            if (prev && !b_cs_n) falls++;
            prev = b_cs_n;
            if (b_rsp_valid) begin
                got = 1'b1;
                tout_b = b_rsp_timeout;
                data_b = b_rsp_data;
            end
        end
        check("tmo_rsp_seen", 32'(got), 32'd1);
        check("tmo_strobes", 32'(falls), 32'd1);
        check("tmo_cs_low_len", 32'(lo >= 7 && lo <= 9), 32'd1);
        check("tmo_rsp", 32'({data_b, tout_b}), 32'({16'h0000, 1'b1}));

        // Reset during the odd-byte strobe.
        ack_odd = 1'b0;
        push_strobes(1'b1, 4'h6, 16'hBEEF);
        base = strobes;
        send(1'b1, 4'h6, 16'hBEEF);
        n = 0;
        while (strobes < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_odd_strobe_seen", 32'(strobes), 32'(base + 2));
        @(negedge clk);
        check("abort_pre_drive", 32'({bus_cs_n, bus_data_oe, rsp_data}), 32'({2'b01, 16'hC33C}));
        base = rsps;
        #2 reset_n = 1'b0;
        #1 check("abort_async", 32'({bus_cs_n, bus_data_oe, req_ready, rsp_valid, rsp_data}),
                 32'({4'b1000, 16'h0000}));
        @(negedge clk) reset_n = 1'b1;
        ack_odd = 1'b1;
        @(posedge clk);
        #1 check("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("abort_no_rsp", 32'(rsps), 32'(base));

        check("queues_drained", 32'(exp_strobes.size() + exp_rsps.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
